pwm_capture: RTL and testbench

Receive-side counterpart of the PWM generator. It samples an asynchronous PWM waveform and measures its period and high time in clk cycles. It then computes an 8-bit duty value on the same 0..255 scale the generator uses (duty d at a 256-cycle period reads back as d). It also flags a line stuck at 0% or 100%. It sits on feedback/loopback paths and on boards that decode external PWM inputs.

---
 rtl/pwm_capture.sv | 159 +++++++++++++++
 tb/tb_pwm_capture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input and
// converts them to an 8-bit duty value with a serial restoring divider.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [7:0]       duty_cycle,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             duty_valid,
  output logic             stuck,
  output logic             overrun
);

  // state   | meaning
  // IDLE    | after reset, waiting for the first rise (first period is partial)
  // MEASURE | counting period/high time between rises
  // STUCK   | no rise for TIMEOUT cycles, line declared stuck at its level
  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t state_q, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise;
  logic [CNT_W-1:0]       period_cnt, high_cnt;
  logic [CNT_W-1:0]       plen_q, hlen_q, rem_q, rem_nx;
  logic [CNT_W:0]         rem_sh;
  logic [7:0]             quo_q, q_fin;
  logic [2:0]             it_q;
  logic                   busy_q, clamp_q, ge, div_done;
  logic                   start_req, start, enter_stuck, stuck_pend_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      else                 sync_q <= pwm_in;
      s_d <= s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx    = state_q;
    enter_stuck = 1'b0;
    start_req   = 1'b0;
    case (state_q)
      IDLE:    if (rise) state_nx = MEASURE;
      MEASURE: begin
        if (rise) begin
          start_req = 1'b1;
        end else if (period_cnt >= TIMEOUT_C) begin
          enter_stuck = 1'b1;
          state_nx    = STUCK;
        end
      end
      STUCK:   if (rise) state_nx = MEASURE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_ONE;
      high_cnt   <= CNT_ONE;
    end else if (state_q == MEASURE) begin
      if (period_cnt != CNT_MAX)     period_cnt <= period_cnt + CNT_ONE;
      if (s && high_cnt != CNT_MAX)  high_cnt   <= high_cnt + CNT_ONE;
    end
  end

  // One quotient bit per cycle; a rise on the final iteration may start anew.
  assign rem_sh   = {rem_q, 1'b0};
  assign ge       = rem_sh >= {1'b0, plen_q};
  assign rem_nx   = ge ? CNT_W'(rem_sh - {1'b0, plen_q}) : rem_sh[CNT_W-1:0];
  assign q_fin    = clamp_q ? 8'hFF : {quo_q[6:0], ge};
  assign div_done = busy_q && (it_q == 3'd7);
  assign start    = start_req && (!busy_q || div_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      plen_q  <= '0;
      hlen_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      it_q    <= '0;
      busy_q  <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      if (busy_q) begin
        rem_q <= rem_nx;
        quo_q <= {quo_q[6:0], ge};
        it_q  <= it_q + 3'd1;
        if (div_done) busy_q <= 1'b0;
      end
      if (start) begin
        plen_q  <= period_cnt;
        hlen_q  <= high_cnt;
        rem_q   <= high_cnt;
        quo_q   <= '0;
        it_q    <= '0;
        busy_q  <= 1'b1;
        clamp_q <= high_cnt >= period_cnt;
      end
    end
  end

  // A timeout coinciding with a divider result is deferred by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_cycle   <= '0;
      period       <= '0;
      high_time    <= '0;
      duty_valid   <= 1'b0;
      stuck        <= 1'b0;
      overrun      <= 1'b0;
      stuck_pend_q <= 1'b0;
    end else begin
      duty_valid   <= 1'b0;
      overrun      <= start_req && busy_q && !div_done;
      stuck_pend_q <= enter_stuck && div_done;
      if (div_done) begin
        duty_cycle <= q_fin;
        period     <= plen_q;
        high_time  <= hlen_q;
        duty_valid <= 1'b1;
      end
      if ((enter_stuck && !div_done) || stuck_pend_q) begin
        stuck      <= 1'b1;
        duty_cycle <= s ? 8'hFF : 8'h00;
        period     <= '0;
        high_time  <= '0;
        duty_valid <= 1'b1;
      end
      if (state_q == STUCK && rise) stuck <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a timestamp-based reference model predicts
// every duty_valid event and the number of overrun pulses.
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pwm_in = 1'b0;
  logic [7:0]       duty_cycle;
  logic [CNT_W-1:0] period, high_time;
  logic             duty_valid, stuck, overrun;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .duty_cycle(duty_cycle), .period(period), .high_time(high_time),
    .duty_valid(duty_valid), .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int duty;
    int per;
    int hi;
    int stk;
    int tc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   mode = 0;            // 0 waiting for first rise, 1 measuring, 2 stuck
  int   t_rise = 0;
  int   hcnt = 0;
  int   last_start = -1000;
  int   ovr_exp = 0;
  int   ovr_seen = 0;
  logic prev = 1'b0;

  // Reference: each rise closes a period of (now - last rise) cycles; a new
  // division is refused if fewer than 8 cycles have passed since the last one.
  always @(posedge clk) begin
    logic p;
    exp_t e;
    cyc++;
    if (!rst) begin
      mode = 0;
      prev = 1'b0;
      last_start = -1000;
      sb.delete();
    end else begin
      p = pwm_in;
      if (p && !prev) begin
        if (mode == 1) begin
          if (cyc - last_start < 8) begin
            ovr_exp++;
          end else begin
            e.per  = cyc - t_rise;
            e.hi   = hcnt;
            e.duty = (hcnt >= e.per) ? 255 : (hcnt * 256) / e.per;
            e.stk  = 0;
            e.tc   = cyc;
            sb.push_back(e);
            last_start = cyc;
          end
        end
        mode   = 1;
        t_rise = cyc;
        hcnt   = 1;
      end else if (mode == 1) begin
        hcnt += int'(p);
        if (cyc - t_rise >= TIMEOUT) begin
          e.per  = 0;
          e.hi   = 0;
          e.duty = p ? 255 : 0;
          e.stk  = 1;
          e.tc   = cyc;
          sb.push_back(e);
          mode = 2;
        end
      end
      prev = p;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (overrun) ovr_seen++;
      if (duty_valid) begin
        if (sb.size() == 0) begin
          chk("dv_unexpected", 32'(duty_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("duty",      32'(duty_cycle), e.duty);
          chk("period",    32'(period),     e.per);
          chk("high_time", 32'(high_time),  e.hi);
          chk("stuck",     32'(stuck),      e.stk);
          if (e.stk == 0)
            chk("latency_ok", 32'((cyc - e.tc >= 9) && (cyc - e.tc <= 12)), 32'd1);
        end
      end
    end
  end

  task automatic pwm(input int hi, input int lo);
    repeat (hi) begin @(negedge clk); pwm_in = 1'b1; end
    repeat (lo) begin @(negedge clk); pwm_in = 1'b0; end
  endtask

  task automatic hold(input logic lvl, input int n);
    repeat (n) begin @(negedge clk); pwm_in = lvl; end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({duty_cycle, period, high_time, duty_valid, stuck, overrun}), 32'd0);
  endtask

  initial begin
    int per, hi;
    repeat (4) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b1;

    repeat (4) pwm(128, 128);
    pwm(64, 192);
    pwm(192, 64);
    pwm(255, 1);
    pwm(128, 128);
    chk("stuck_in_traffic", 32'(stuck), 32'd0);
    hold(1'b0, TIMEOUT + 50);
    chk("stuck_low", 32'(stuck), 32'd1);

    pwm(128, 128);
    hold(1'b0, 4);
    chk("stuck_cleared", 32'(stuck), 32'd0);
    repeat (2) pwm(128, 128);

    hold(1'b1, TIMEOUT + 50);
    chk("stuck_high", 32'(stuck), 32'd1);
    chk("stuck_high_duty", 32'(duty_cycle), 32'd255);
    hold(1'b0, 20);
    repeat (3) pwm(100, 60);
    chk("stuck_recovered", 32'(stuck), 32'd0);

    repeat (12) pwm(3, 3);
    pwm(128, 128);

    repeat (20) begin
      per = int'($urandom_range(12, 300));
      hi  = int'($urandom_range(1, per - 1));
      pwm(hi, per - hi);
    end

    // Reset during an in-flight division, then two rises before a reading.
    pwm(6, 0);
    rst = 1'b0;
    #1;
    chk_zero("reset_async");
    repeat (3) @(negedge clk);
    chk_zero("reset_held");
    rst = 1'b1;
    hold(1'b1, 122);
    hold(1'b0, 128);
    chk_zero("post_reset_quiet");
    repeat (2) pwm(128, 128);
    hold(1'b0, 40);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 3_000_000);
    $fatal(1);
  end

endmodule
